descriptor_reader: RTL and testbench



---
 rtl/sift_desc_pkg.sv | 23 ++
 rtl/descriptor_reader.sv | 124 ++++++++++++
 tb/tb_descriptor_reader.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sift_desc_pkg.sv
// Shared definitions for the SIFT descriptor generator and reader so both
// sides agree on histogram word width and descriptor packing.
package sift_desc_pkg;

    localparam int PATCH_SIZE = 4;

    // One histogram word per 2x2 sub-patch; bin counts need clog2(cells)+1 bits,
    // and each word carries 8 such bins.
    function automatic int calc_word_width(input int patch);
        return ($clog2(patch / 2 * patch / 2) + 1) * 8;
    endfunction

    localparam int WORD_WIDTH = calc_word_width(PATCH_SIZE);
    localparam int DESC_WIDTH = 4 * WORD_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_PRESENT,
        ST_FINISH
    } reader_state_t;

endpackage

// File: rtl/descriptor_reader.sv
// Drains the descriptor BRAM four words at a time and presents each packed
// keypoint descriptor on a valid/ready stream.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | waiting for start; outputs quiet
// ST_FETCH   | reading the four sub-patch words of the current keypoint
// ST_PRESENT | descriptor on desc_out, waiting for desc_ready
// ST_FINISH  | done pulse is high for this one cycle
module descriptor_reader
    import sift_desc_pkg::*;
#(
    parameter int NUMBER_DESCRIPTORS = 4000,
    parameter int NUMBER_KEYPOINTS   = 1000,
    parameter int PATCH_SIZE         = sift_desc_pkg::PATCH_SIZE,
    parameter int BRAM_LATENCY       = 2,
    localparam int AW = $clog2(NUMBER_DESCRIPTORS),
    localparam int KW = $clog2(NUMBER_KEYPOINTS) + 1,
    localparam int WW = calc_word_width(PATCH_SIZE)
) (
    input  logic            clk,
    input  logic            rst_in,
    input  logic            start,
    input  logic [KW-1:0]   kp_count,
    output logic [AW-1:0]   desc_read_addr,
    input  logic [WW-1:0]   desc_read_data,
    output logic [4*WW-1:0] desc_out,
    output logic [KW-1:0]   kp_index,
    output logic            desc_valid,
    input  logic            desc_ready,
    output logic            busy,
    output logic            done
);

    localparam int WCW    = $clog2(BRAM_LATENCY + 1);
    localparam int MAX_KP = NUMBER_DESCRIPTORS / 4;

    reader_state_t  state;
    logic [KW-1:0]  count_q;
    logic [KW-1:0]  kp_clamped;
    logic [1:0]     word_cnt;
    logic [WCW-1:0] wait_cnt;

    // Limit the requested count so the reads never run past the BRAM.
    always_comb begin
        kp_clamped = kp_count;
        if (int'(kp_count) * 4 > NUMBER_DESCRIPTORS) begin
            kp_clamped = KW'(MAX_KP);
        end
    end

    // Reader FSM; desc_out doubles as the 4-slot capture register, which is
    // safe because slots are only written while desc_valid is low.
    always_ff @(posedge clk) begin
        if (rst_in) begin
            state          <= ST_IDLE;
            count_q        <= '0;
            word_cnt       <= '0;
            wait_cnt       <= '0;
            desc_read_addr <= '0;
            desc_out       <= '0;
            kp_index       <= '0;
            desc_valid     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        count_q        <= kp_clamped;
                        kp_index       <= '0;
                        desc_read_addr <= '0;
                        word_cnt       <= '0;
                        wait_cnt       <= '0;
                        busy           <= 1'b1;
                        if (kp_clamped == '0) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (wait_cnt == WCW'(BRAM_LATENCY)) begin
                        desc_out[int'(word_cnt)*WW +: WW] <= desc_read_data;
                        wait_cnt <= '0;
                        word_cnt <= word_cnt + 2'd1;
                        if (desc_read_addr != AW'(NUMBER_DESCRIPTORS - 1)) begin
                            desc_read_addr <= desc_read_addr + AW'(1);
                        end
                        if (word_cnt == 2'd3) begin
                            desc_valid <= 1'b1;
                            state      <= ST_PRESENT;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + WCW'(1);
                    end
                end
                ST_PRESENT: begin
                    if (desc_ready) begin
                        desc_valid <= 1'b0;
                        kp_index   <= kp_index + KW'(1);
                        if (({1'b0, kp_index} + (KW+1)'(1)) < {1'b0, count_q}) begin
                            state <= ST_FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_descriptor_reader.sv
// Bench for descriptor_reader: BRAM model with 2-cycle latency, a scoreboard
// of expected descriptors filled at start, and a table of run scenarios.
module tb_descriptor_reader;
    import sift_desc_pkg::*;

    localparam int ND = 4000;
    localparam int NK = 1000;
    localparam int AW = $clog2(ND);
    localparam int KW = $clog2(NK) + 1;
    localparam int WW = WORD_WIDTH;
    localparam int DW = DESC_WIDTH;

    logic          clk;
    logic          rst_in;
    logic          start;
    logic [KW-1:0] kp_count;
    logic [AW-1:0] desc_read_addr;
    logic [WW-1:0] desc_read_data;
    logic [DW-1:0] desc_out;
    logic [KW-1:0] kp_index;
    logic          desc_valid;
    logic          desc_ready;
    logic          busy;
    logic          done;

    descriptor_reader #(
        .NUMBER_DESCRIPTORS(ND),
        .NUMBER_KEYPOINTS(NK),
        .PATCH_SIZE(4),
        .BRAM_LATENCY(2)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .start(start),
        .kp_count(kp_count),
        .desc_read_addr(desc_read_addr),
        .desc_read_data(desc_read_data),
        .desc_out(desc_out),
        .kp_index(kp_index),
        .desc_valid(desc_valid),
        .desc_ready(desc_ready),
        .busy(busy),
        .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model: address registered, then output registered -> 2-cycle latency
    logic [WW-1:0] mem [0:4095];
    logic [WW-1:0] bram_p1;
    always @(posedge clk) begin
        bram_p1        <= mem[desc_read_addr];
        desc_read_data <= bram_p1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [DW-1:0] desc;
        int            idx;
    } sb_t;
    sb_t sb_q[$];
    sb_t sb_e;

    // Ready generator: 0 = always ready, 1 = stall each descriptor >10 cycles, 2 = random
    int rdy_mode = 0;
    int vcnt = 0;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            1: begin
                if (desc_valid) vcnt++;
                else vcnt = 0;
                desc_ready = (vcnt > 10);
            end
            2: desc_ready = 1'($urandom_range(0, 1));
            default: desc_ready = 1'b1;
        endcase
    end

    // Monitor: handshakes against scoreboard, stability under stall, done count
    logic [DW-1:0] prev_desc;
    logic [KW-1:0] prev_idx;
    bit            prev_hold = 0;
    int            hs_count = 0;
    int            done_count = 0;
    int            max_addr = 0;
    always @(negedge clk) begin
        if (rst_in) begin
            prev_hold = 0;
        end else begin
            if (prev_hold && desc_valid) begin
                check("hold_desc", desc_out, prev_desc);
                check("hold_idx", kp_index, prev_idx);
            end
            if (desc_valid && desc_ready) begin
                hs_count++;
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_desc actual=kp_index %0d required=no descriptor", kp_index);
                end else begin
                    sb_e = sb_q.pop_front();
                    check("desc_out", desc_out, sb_e.desc);
                    check("kp_index", kp_index, sb_e.idx);
                end
            end
            prev_hold = desc_valid && !desc_ready;
            prev_desc = desc_out;
            prev_idx  = kp_index;
            if (done) done_count++;
            if (int'(desc_read_addr) > max_addr) max_addr = int'(desc_read_addr);
        end
    end

    typedef struct {
        int kp;
        int mode;
        bit extra_start;
        int exp_n;
        int exp_first;
        int exp_done_cycle;
    } row_t;

    localparam int NROWS = 6;
    row_t rows [NROWS];
    row_t row;

    int cyc, first_v, done_c, last_hs, timeout, exp_max;
    bit prev_v;

    initial begin
        rst_in     = 1'b1;
        start      = 1'b0;
        kp_count   = '0;
        desc_ready = 1'b1;
        for (int i = 0; i < 4096; i++) mem[i] = WW'((i * 40503) ^ 24'hA5C3E1);
        mem[0] = 24'h000001;
        mem[1] = 24'h000010;
        mem[2] = 24'h000100;
        mem[3] = 24'h001000;

        //          kp    mode extra n     first done
        rows[0] = '{1,    0,   0,    1,    12,   13};
        rows[1] = '{2,    1,   0,    2,    12,   -1};
        rows[2] = '{0,    0,   0,    0,    -1,   0};
        rows[3] = '{3,    2,   0,    3,    12,   -1};
        rows[4] = '{1000, 0,   1,    1000, 12,   -1};
        rows[5] = '{1500, 0,   0,    1000, 12,   -1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr", desc_read_addr, 0);
        check("rst_desc", desc_out, 0);
        check("rst_idx", kp_index, 0);
        check("rst_valid", desc_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst_in = 1'b0;

        // Reset in the middle of fetching word 2: everything discarded, no done
        done_count = 0;
        @(posedge clk); #1;
        kp_count = KW'(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("mid_busy_pre", busy, 1);
        rst_in = 1'b1;
        @(posedge clk); #1;
        rst_in = 1'b0;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", desc_valid, 0);
        check("mid_rst_addr", desc_read_addr, 0);
        check("mid_rst_desc", desc_out, 0);
        repeat (6) @(posedge clk);
        #1;
        check("mid_rst_no_done", done_count, 0);
        check("mid_rst_no_hs", hs_count, 0);

        for (int r = 0; r < NROWS; r++) begin
            row = rows[r];
            rdy_mode = row.mode;
            sb_q.delete();
            for (int k = 0; k < row.exp_n; k++) begin
                sb_e.desc = {mem[4*k+3], mem[4*k+2], mem[4*k+1], mem[4*k]};
                sb_e.idx  = k;
                sb_q.push_back(sb_e);
            end
            exp_max = (row.exp_n == 0) ? 0 : ((4 * row.exp_n < ND - 1) ? 4 * row.exp_n : ND - 1);
            hs_count   = 0;
            done_count = 0;
            @(posedge clk); #1;
            kp_count = KW'(row.kp);
            start = 1'b1;
            @(posedge clk); #1;
            start    = 1'b0;
            max_addr = 0;
            cyc      = 0;
            first_v  = -1;
            done_c   = -1;
            last_hs  = 0;
            prev_v   = 0;
            timeout  = 30 * row.exp_n + 50;
            while (1) begin
                if (desc_valid && !prev_v) begin
                    if (first_v < 0) first_v = cyc;
                    else check("refetch_gap", cyc - last_hs, 12);
                end
                if (!desc_valid && prev_v) last_hs = cyc;
                prev_v = desc_valid;
                if (done && done_c < 0) done_c = cyc;
                if (done_c >= 0 && cyc >= done_c + 3) break;
                if (cyc > timeout) begin
                    checks++;
                    errors++;
                    $display("FAIL timeout row %0d actual=no done after %0d cycles required=done", r, cyc);
                    break;
                end
                if (row.extra_start && cyc == 5) begin
                    start    = 1'b1;
                    kp_count = KW'(1);
                end else begin
                    start = 1'b0;
                end
                @(posedge clk); #1;
                cyc++;
            end
            start = 1'b0;
            check("first_valid", first_v, row.exp_first);
            if (row.exp_done_cycle >= 0) check("done_cycle", done_c, row.exp_done_cycle);
            check("handshakes", hs_count, row.exp_n);
            check("done_pulses", done_count, 1);
            check("sb_empty", sb_q.size(), 0);
            check("end_busy", busy, 0);
            check("end_valid", desc_valid, 0);
            check("max_addr", max_addr, exp_max);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
